// File: rtl/exec_stage.sv
// exec_stage: RV32I execute stage. Holds the ID/EX register, forwards operands,
// runs the ALU, resolves branches/jumps into a redirect and drives the EX/MEM register.
// ALU codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
module exec_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_ex,
  input  logic            flush_ex,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [3:0]      id_alucontrol,
  input  logic            id_inv_br,
  input  logic [1:0]      id_a_sel,
  input  logic            id_b_sel,
  input  logic [2:0]      id_kind,
  input  logic            id_reg_write,
  input  logic [2:0]      id_funct3,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            mem_valid,
  output logic [2:0]      mem_kind,
  output logic [2:0]      mem_funct3,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd,
  output logic            mem_reg_write,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] KIND_BRANCH = 3'd1;
  localparam logic [2:0] KIND_JAL    = 3'd2;
  localparam logic [2:0] KIND_JALR   = 3'd3;
  localparam logic [2:0] KIND_LOAD   = 3'd4;
  localparam logic [2:0] KIND_STORE  = 3'd5;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alucontrol;
    logic            inv_br;
    logic [1:0]      a_sel;
    logic            b_sel;
    logic [2:0]      kind;
    logic            reg_write;
    logic [2:0]      funct3;
  } idex_t;

  typedef struct packed {
    logic            valid;
    logic [2:0]      kind;
    logic [2:0]      funct3;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_write;
  } exmem_t;

  idex_t           idex_q, idex_d;
  exmem_t          exmem_q, exmem_d;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_result, ex_result, target;
  logic [4:0]      shamt;
  logic            taken;

  // Operand forwarding: EX/MEM (non-load) beats WB beats register file; x0 never forwarded
  always_comb begin
    fwd_rs1 = idex_q.rs1_val;
    fwd_rs2 = idex_q.rs2_val;
    if (idex_q.rs1 != 5'd0) begin
      if (exmem_q.valid && exmem_q.reg_write && exmem_q.rd == idex_q.rs1 && exmem_q.kind != KIND_LOAD)
        fwd_rs1 = exmem_q.result;
      else if (wb_reg_write && wb_rd == idex_q.rs1)
        fwd_rs1 = wb_data;
    end
    if (idex_q.rs2 != 5'd0) begin
      if (exmem_q.valid && exmem_q.reg_write && exmem_q.rd == idex_q.rs2 && exmem_q.kind != KIND_LOAD)
        fwd_rs2 = exmem_q.result;
      else if (wb_reg_write && wb_rd == idex_q.rs2)
        fwd_rs2 = wb_data;
    end
  end

  // Operand select, ALU, branch/jump resolution and EX result
  always_comb begin
    op_a = '0;
    case (idex_q.a_sel)
      2'd0:    op_a = fwd_rs1;
      2'd1:    op_a = idex_q.pc;
      default: op_a = '0;
    endcase
    op_b  = idex_q.b_sel ? idex_q.imm : fwd_rs2;
    shamt = op_b[4:0];

    alu_result = '0;
    case (idex_q.alucontrol)
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_SLL:  alu_result = op_a << shamt;
      ALU_SLT:  alu_result = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_result = XLEN'(op_a < op_b);
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_SRL:  alu_result = op_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_result = op_a | op_b;
      ALU_AND:  alu_result = op_a & op_b;
      default:  alu_result = '0;
    endcase

    taken  = (alu_result == '0) ^ idex_q.inv_br;
    target = (idex_q.kind == KIND_JALR) ? ((fwd_rs1 + idex_q.imm) & ~XLEN'(1))
                                        : (idex_q.pc + idex_q.imm);

    case (idex_q.kind)
      KIND_JAL, KIND_JALR:  ex_result = idex_q.pc + XLEN'(4);
      KIND_LOAD, KIND_STORE: ex_result = op_a + op_b;
      default:              ex_result = alu_result;
    endcase

    redirect_valid = idex_q.valid && !stall_ex &&
                     (idex_q.kind == KIND_JAL || idex_q.kind == KIND_JALR ||
                      (idex_q.kind == KIND_BRANCH && taken));
    redirect_pc    = target;
  end

  // ID/EX next value: hold on stall, bubble on flush/redirect, else capture decode
  always_comb begin
    idex_d = idex_q;
    if (!stall_ex) begin
      if (flush_ex || redirect_valid || !id_valid) begin
        idex_d = '0;
      end else begin
        idex_d.valid      = 1'b1;
        idex_d.pc         = id_pc;
        idex_d.imm        = id_imm;
        idex_d.rs1_val    = id_rs1_val;
        idex_d.rs2_val    = id_rs2_val;
        idex_d.rs1        = id_rs1;
        idex_d.rs2        = id_rs2;
        idex_d.rd         = id_rd;
        idex_d.alucontrol = id_alucontrol;
        idex_d.inv_br     = id_inv_br;
        idex_d.a_sel      = id_a_sel;
        idex_d.b_sel      = id_b_sel;
        idex_d.kind       = id_kind;
        idex_d.reg_write  = id_reg_write;
        idex_d.funct3     = id_funct3;
      end
    end
  end

  // EX/MEM next value: hold on stall; branches, stores and rd=x0 never write back
  always_comb begin
    exmem_d = exmem_q;
    if (!stall_ex) begin
      exmem_d.valid      = idex_q.valid;
      exmem_d.kind       = idex_q.kind;
      exmem_d.funct3     = idex_q.funct3;
      exmem_d.result     = ex_result;
      exmem_d.store_data = fwd_rs2;
      exmem_d.rd         = idex_q.rd;
      exmem_d.reg_write  = idex_q.reg_write && idex_q.rd != 5'd0 &&
                           idex_q.kind != KIND_BRANCH && idex_q.kind != KIND_STORE;
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end

  assign mem_valid      = exmem_q.valid;
  assign mem_kind       = exmem_q.kind;
  assign mem_funct3     = exmem_q.funct3;
  assign mem_result     = exmem_q.result;
  assign mem_store_data = exmem_q.store_data;
  assign mem_rd         = exmem_q.rd;
  assign mem_reg_write  = exmem_q.reg_write;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: ALU ops, forwarding, branch/jump redirect, stall, reset, flush.
module tb_exec_stage;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                         XOR_ = 4'd5, SRL = 4'd6, SRA = 4'd7, OR_ = 4'd8, AND_ = 4'd9;
  localparam logic [2:0] K_ALU = 3'd0, K_BR = 3'd1, K_JAL = 3'd2, K_JALR = 3'd3, K_LD = 3'd4;

  logic        clk = 1'b0;
  logic        rst, stall_ex, flush_ex, id_valid;
  logic [31:0] id_pc, id_imm, id_rs1_val, id_rs2_val;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alucontrol;
  logic        id_inv_br;
  logic [1:0]  id_a_sel;
  logic        id_b_sel;
  logic [2:0]  id_kind;
  logic        id_reg_write;
  logic [2:0]  id_funct3;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_valid, mem_reg_write, redirect_valid;
  logic [2:0]  mem_kind, mem_funct3;
  logic [31:0] mem_result, mem_store_data, redirect_pc;
  logic [4:0]  mem_rd;

  int checks = 0;
  int errors = 0;

  exec_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .flush_ex(flush_ex),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alucontrol(id_alucontrol), .id_inv_br(id_inv_br),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_kind(id_kind),
    .id_reg_write(id_reg_write), .id_funct3(id_funct3),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_valid(mem_valid), .mem_kind(mem_kind), .mem_funct3(mem_funct3),
    .mem_result(mem_result), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [2:0] kind, input logic [3:0] ctrl,
                        input logic inv, input logic [1:0] asel, input logic bsel,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] rs1, input logic [31:0] rs1v,
                        input logic [4:0] rs2, input logic [31:0] rs2v,
                        input logic [4:0] rd, input logic rw);
    id_valid = v; id_kind = kind; id_alucontrol = ctrl; id_inv_br = inv;
    id_a_sel = asel; id_b_sel = bsel; id_pc = pc; id_imm = imm;
    id_rs1 = rs1; id_rs1_val = rs1v; id_rs2 = rs2; id_rs2_val = rs2v;
    id_rd = rd; id_reg_write = rw; id_funct3 = 3'd2;
  endtask

  task automatic clr_id();
    set_id(1'b0, K_ALU, ADD, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
  endtask

  // Single ALU instruction through the stage, result checked two edges later
  task automatic alu_vec(input string tag, input logic [3:0] ctrl, input logic [1:0] asel,
                         input logic bsel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    set_id(1'b1, K_ALU, ctrl, 1'b0, asel, bsel, 32'h0, b, 5'd20, a, 5'd21, b, 5'd22, 1'b1);
    tick();
    clr_id();
    tick();
    chk(tag, mem_result, exp);
  endtask

  initial begin
    rst = 1'b1; stall_ex = 1'b0; flush_ex = 1'b0;
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    clr_id();
    tick(); tick();
    rst = 1'b0;
    chk("reset_mem_valid", 32'(mem_valid), 32'h0);
    chk("reset_mem_rw", 32'(mem_reg_write), 32'h0);
    chk("reset_redirect", 32'(redirect_valid), 32'h0);
    chk("reset_result", mem_result, 32'h0);

    // ALU operation table
    alu_vec("alu_add",  ADD,  2'd0, 1'b0, 32'h7fffffff, 32'h1, 32'h80000000);
    alu_vec("alu_sub",  SUB,  2'd0, 1'b0, 32'h0, 32'h1, 32'hffffffff);
    alu_vec("alu_sll",  SLL,  2'd0, 1'b0, 32'h1, 32'h21, 32'h2);
    alu_vec("alu_srl",  SRL,  2'd0, 1'b0, 32'h80000000, 32'h4, 32'h08000000);
    alu_vec("alu_sra",  SRA,  2'd0, 1'b0, 32'h80000000, 32'h4, 32'hf8000000);
    alu_vec("alu_slt",  SLT,  2'd0, 1'b0, 32'hffffffff, 32'h1, 32'h1);
    alu_vec("alu_sltu", SLTU, 2'd0, 1'b0, 32'hffffffff, 32'h1, 32'h0);
    alu_vec("alu_xor",  XOR_, 2'd0, 1'b0, 32'hf0f0, 32'hff00, 32'h0ff0);
    alu_vec("alu_or",   OR_,  2'd0, 1'b0, 32'hf0f0, 32'h0f0f, 32'hffff);
    alu_vec("alu_and",  AND_, 2'd0, 1'b0, 32'hf0f0, 32'hff00, 32'hf000);
    alu_vec("alu_undef", 4'd15, 2'd0, 1'b0, 32'h1234, 32'h5678, 32'h0);
    alu_vec("asel3_zero", ADD, 2'd3, 1'b1, 32'h5, 32'h6, 32'h6);

    // addi x1,x0,5 ; add x2,x1,x1 (EX/MEM forwarding)
    set_id(1'b1, K_ALU, ADD, 1'b0, 2'd0, 1'b1, 32'h0, 32'h5, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 1'b1);
    tick();
    set_id(1'b1, K_ALU, ADD, 1'b0, 2'd0, 1'b0, 32'h4, 32'h0, 5'd1, 32'h0, 5'd1, 32'h0, 5'd2, 1'b1);
    tick();
    chk("addi_result", mem_result, 32'h5);
    clr_id();
    tick();
    chk("fwd_add_result", mem_result, 32'd10);
    chk("fwd_add_rd", 32'(mem_rd), 32'd2);
    chk("fwd_add_rw", 32'(mem_reg_write), 32'h1);

    // x3: EX/MEM=9 and WB=7 together, EX/MEM wins
    set_id(1'b1, K_ALU, ADD, 1'b0, 2'd0, 1'b1, 32'h0, 32'h9, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 1'b1);
    tick();
    set_id(1'b1, K_ALU, ADD, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0, 5'd3, 32'h1, 5'd0, 32'h0, 5'd4, 1'b1);
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'd7;
    tick();
    clr_id();
    tick();
    chk("fwd_priority", mem_result, 32'd9);

    // Same with rd=x0: register value used
    set_id(1'b1, K_ALU, ADD, 1'b0, 2'd0, 1'b1, 32'h0, 32'h9, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b1);
    tick();
    set_id(1'b1, K_ALU, ADD, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0, 5'd0, 32'h11, 5'd0, 32'h0, 5'd4, 1'b1);
    wb_rd = 5'd0;
    tick();
    chk("rd0_no_write", 32'(mem_reg_write), 32'h0);
    clr_id();
    tick();
    chk("fwd_x0_regval", mem_result, 32'h11);

    // WB-only forwarding
    set_id(1'b1, K_ALU, ADD, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0, 5'd5, 32'h1, 5'd0, 32'h0, 5'd4, 1'b1);
    wb_rd = 5'd5;
    tick();
    clr_id();
    tick();
    chk("fwd_wb_only", mem_result, 32'd7);
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;

    // Load in EX/MEM is not a forwarding source
    set_id(1'b1, K_LD, ADD, 1'b0, 2'd0, 1'b1, 32'h0, 32'h100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 1'b1);
    tick();
    set_id(1'b1, K_ALU, ADD, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0, 5'd6, 32'h20, 5'd0, 32'h0, 5'd4, 1'b1);
    tick();
    chk("load_addr", mem_result, 32'h100);
    chk("load_kind", 32'(mem_kind), 32'd4);
    clr_id();
    tick();
    chk("load_no_fwd", mem_result, 32'h20);

    // bne with equal operands: not taken
    set_id(1'b1, K_BR, SUB, 1'b1, 2'd0, 1'b0, 32'h80, 32'h10, 5'd7, 32'h4, 5'd8, 32'h4, 5'd0, 1'b0);
    tick();
    chk("bne_not_taken", 32'(redirect_valid), 32'h0);
    clr_id();
    tick();
    chk("bne_no_write", 32'(mem_reg_write), 32'h0);
    chk("bne_valid", 32'(mem_valid), 32'h1);

    // blt -1 < 1: taken, younger instruction squashed
    set_id(1'b1, K_BR, SLT, 1'b1, 2'd0, 1'b0, 32'h100, 32'h40, 5'd7, 32'hffffffff, 5'd8, 32'h1, 5'd0, 1'b0);
    tick();
    chk("blt_redirect", 32'(redirect_valid), 32'h1);
    chk("blt_target", redirect_pc, 32'h140);
    set_id(1'b1, K_ALU, ADD, 1'b0, 2'd0, 1'b1, 32'h104, 32'h3, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 1'b1);
    tick();
    chk("blt_in_mem", 32'(mem_valid), 32'h1);
    chk("blt_once", 32'(redirect_valid), 32'h0);
    clr_id();
    tick();
    chk("blt_squash", 32'(mem_valid), 32'h0);

    // jalr rs1=0x1003, imm=4, pc=0x200
    set_id(1'b1, K_JALR, ADD, 1'b0, 2'd0, 1'b1, 32'h200, 32'h4, 5'd10, 32'h1003, 5'd0, 32'h0, 5'd1, 1'b1);
    tick();
    chk("jalr_redirect", 32'(redirect_valid), 32'h1);
    chk("jalr_target", redirect_pc, 32'h1006);
    clr_id();
    tick();
    chk("jalr_link", mem_result, 32'h204);
    chk("jalr_rw", 32'(mem_reg_write), 32'h1);

    // Taken beq held under a 3-cycle stall (flush during stall is ignored)
    set_id(1'b1, K_ALU, ADD, 1'b0, 2'd0, 1'b1, 32'h0, 32'h55, 5'd0, 32'h0, 5'd0, 32'h0, 5'd11, 1'b1);
    tick();
    set_id(1'b1, K_BR, SUB, 1'b0, 2'd0, 1'b0, 32'h300, 32'h20, 5'd12, 32'h3, 5'd13, 32'h3, 5'd0, 1'b0);
    tick();
    set_id(1'b1, K_ALU, ADD, 1'b0, 2'd1, 1'b1, 32'h304, 32'h1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd14, 1'b1);
    stall_ex = 1'b1;
    #1;
    chk("stall_redirect_0", 32'(redirect_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      flush_ex = (i == 1);
      tick();
      chk("stall_redirect", 32'(redirect_valid), 32'h0);
      chk("stall_mem_hold", mem_result, 32'h55);
      chk("stall_rd_hold", 32'(mem_rd), 32'd11);
      chk("stall_idex_hold", redirect_pc, 32'h320);
    end
    flush_ex = 1'b0;
    stall_ex = 1'b0;
    #1;
    chk("unstall_redirect", 32'(redirect_valid), 32'h1);
    chk("unstall_target", redirect_pc, 32'h320);
    tick();
    chk("beq_in_mem", 32'(mem_kind), 32'(K_BR));
    chk("beq_redirect_once", 32'(redirect_valid), 32'h0);
    clr_id();
    tick();
    chk("beq_squash", 32'(mem_valid), 32'h0);

    // Reset mid-stream with a jal in ID/EX
    set_id(1'b1, K_JAL, ADD, 1'b0, 2'd1, 1'b1, 32'h400, 32'h8, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 1'b1);
    tick();
    chk("jal_redirect", 32'(redirect_valid), 32'h1);
    chk("jal_target", redirect_pc, 32'h408);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr_id();
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    chk("rst_mem_rw", 32'(mem_reg_write), 32'h0);
    chk("rst_redirect", 32'(redirect_valid), 32'h0);

    // flush_ex alone bubbles the incoming instruction
    set_id(1'b1, K_ALU, ADD, 1'b0, 2'd0, 1'b1, 32'h0, 32'h77, 5'd0, 32'h0, 5'd0, 32'h0, 5'd13, 1'b1);
    flush_ex = 1'b1;
    tick();
    flush_ex = 1'b0;
    clr_id();
    tick();
    chk("flush_bubble", 32'(mem_valid), 32'h0);
    chk("flush_no_write", 32'(mem_reg_write), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
